// File: rtl/norm_sched_pkg.sv
// norm_sched_pkg: shared state encoding, sample width and index-width helper for the frame scheduler
package norm_sched_pkg;
    localparam int SAMPLE_W = 32;
    localparam int STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past last_grant
module rr_arbiter
    import norm_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = ch_idx_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last_grant,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  gnt_idx
);
    logic [IW-1:0] idx;

    // scan from the farthest offset down so the nearest requester after last_grant wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NCH);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/norm_frame_scheduler.sv
// norm_frame_scheduler: shares one normalizer between NCH channels frame by frame; NORM_SCHED_TIMEOUT_EN builds the watchdog/flush
module norm_frame_scheduler
    import norm_sched_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CNT       = 1000,
    parameter int TIMEOUT   = 4096,
    parameter int FLUSH_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*SAMPLE_W-1:0] ch_data,
    input  logic [NCH-1:0]          ch_valid,
    output logic [NCH-1:0]          ch_ready,
    output logic [NCH-1:0]          grant,
    output logic                    norm_start_en,
    output logic [SAMPLE_W-1:0]     norm_data,
    output logic                    norm_data_valid,
    input  logic [SAMPLE_W-1:0]     norm_out_data,
    input  logic                    norm_out_valid,
    input  logic                    norm_end_flag,
    output logic                    norm_flush,
    output logic [SAMPLE_W-1:0]     out_data,
    output logic                    out_valid,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic                    frame_done,
    output logic                    frame_ok,
    output logic                    timeout_err,
    output logic                    busy
);
    localparam int IW = ch_idx_w(NCH);
    localparam int FW = $clog2(CNT + 1);

    state_t              state_q, state_d;
    logic [NCH-1:0]      grant_q, grant_d, arb_gnt;
    logic [IW-1:0]       idx_q, idx_d, last_grant_q, last_grant_d, arb_idx;
    logic [FW-1:0]       feed_cnt_q, feed_cnt_d, out_cnt_q, out_cnt_d;
    logic                norm_start_en_q, norm_start_en_d;
    logic                norm_data_valid_q, norm_data_valid_d;
    logic [SAMPLE_W-1:0] norm_data_q, norm_data_d;
    logic                out_valid_q, out_valid_d;
    logic [SAMPLE_W-1:0] out_data_q, out_data_d;
    logic [IW-1:0]       out_ch_q, out_ch_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_ok_q, frame_ok_d;
    logic                xfer, in_wait;
    logic [SAMPLE_W-1:0] sel_data;

`ifdef NORM_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT);
    localparam int CW = $clog2(FLUSH_CYC + 1);
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;
    logic          timed_out_q, timed_out_d;
    logic          timeout_err_q, timeout_err_d;
    logic          norm_flush_q, norm_flush_d;
    logic          expire;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT, FLUSH_CYC};
`endif

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx)
    );

    assign sel_data = ch_data[SAMPLE_W*int'(idx_q) +: SAMPLE_W];
    assign xfer     = (state_q == ST_FEED) && |(ch_valid & grant_q);
    assign in_wait  = state_q == ST_WAIT;
    assign ch_ready = (state_q == ST_FEED) ? grant_q : '0;

    // next-state, counters and registered-output values for the frame sequence
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        idx_d             = idx_q;
        last_grant_d      = last_grant_q;
        feed_cnt_d        = xfer ? feed_cnt_q + 1'b1 : feed_cnt_q;
        out_cnt_d         = (in_wait && norm_out_valid) ? out_cnt_q + 1'b1 : out_cnt_q;
        norm_start_en_d   = 1'b0;
        norm_data_valid_d = xfer;
        norm_data_d       = xfer ? sel_data : norm_data_q;
        out_valid_d       = in_wait && norm_out_valid;
        out_data_d        = out_valid_d ? norm_out_data : out_data_q;
        out_ch_d          = out_valid_d ? idx_q : out_ch_q;
`ifdef NORM_SCHED_TIMEOUT_EN
        wd_cnt_d          = (in_wait && !norm_out_valid) ? wd_cnt_q + 1'b1 : '0;
        flush_cnt_d       = (state_q == ST_FLUSH) ? flush_cnt_q + 1'b1 : '0;
        timed_out_d       = timed_out_q;
        timeout_err_d     = 1'b0;
        norm_flush_d      = 1'b0;
        expire            = in_wait && !norm_out_valid && wd_cnt_q == WW'(TIMEOUT - 1);
`endif
        case (state_q)
            ST_IDLE: if (|req) begin
                grant_d         = arb_gnt;
                idx_d           = arb_idx;
                norm_start_en_d = 1'b1;
                state_d         = ST_START;
            end
            ST_START: state_d = ST_FEED;
            ST_FEED: if (xfer && feed_cnt_q == FW'(CNT - 1)) state_d = ST_WAIT;
            ST_WAIT: begin
                if (norm_end_flag) state_d = ST_DONE;
`ifdef NORM_SCHED_TIMEOUT_EN
                else if (expire) begin
                    state_d       = ST_FLUSH;
                    timeout_err_d = 1'b1;
                    timed_out_d   = 1'b1;
                    norm_flush_d  = 1'b1;
                end
`endif
            end
`ifdef NORM_SCHED_TIMEOUT_EN
            ST_FLUSH: begin
                norm_flush_d = flush_cnt_q != CW'(FLUSH_CYC - 1);
                if (!norm_flush_d) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d      = ST_IDLE;
                grant_d      = '0;
                last_grant_d = idx_q;
                feed_cnt_d   = '0;
                out_cnt_d    = '0;
`ifdef NORM_SCHED_TIMEOUT_EN
                timed_out_d  = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        frame_done_d = state_d == ST_DONE && state_q != ST_DONE;
        frame_ok_d   = frame_done_d && out_cnt_d == FW'(CNT);
`ifdef NORM_SCHED_TIMEOUT_EN
        frame_ok_d   = frame_ok_d && !timed_out_d;
`endif
    end

    // single state register for the FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            grant_q           <= '0;
            idx_q             <= '0;
            last_grant_q      <= IW'(NCH - 1);
            feed_cnt_q        <= '0;
            out_cnt_q         <= '0;
            norm_start_en_q   <= 1'b0;
            norm_data_valid_q <= 1'b0;
            norm_data_q       <= '0;
            out_valid_q       <= 1'b0;
            out_data_q        <= '0;
            out_ch_q          <= '0;
            frame_done_q      <= 1'b0;
            frame_ok_q        <= 1'b0;
`ifdef NORM_SCHED_TIMEOUT_EN
            wd_cnt_q          <= '0;
            flush_cnt_q       <= '0;
            timed_out_q       <= 1'b0;
            timeout_err_q     <= 1'b0;
            norm_flush_q      <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            grant_q           <= grant_d;
            idx_q             <= idx_d;
            last_grant_q      <= last_grant_d;
            feed_cnt_q        <= feed_cnt_d;
            out_cnt_q         <= out_cnt_d;
            norm_start_en_q   <= norm_start_en_d;
            norm_data_valid_q <= norm_data_valid_d;
            norm_data_q       <= norm_data_d;
            out_valid_q       <= out_valid_d;
            out_data_q        <= out_data_d;
            out_ch_q          <= out_ch_d;
            frame_done_q      <= frame_done_d;
            frame_ok_q        <= frame_ok_d;
`ifdef NORM_SCHED_TIMEOUT_EN
            wd_cnt_q          <= wd_cnt_d;
            flush_cnt_q       <= flush_cnt_d;
            timed_out_q       <= timed_out_d;
            timeout_err_q     <= timeout_err_d;
            norm_flush_q      <= norm_flush_d;
`endif
        end
    end

    assign grant           = grant_q;
    assign norm_start_en   = norm_start_en_q;
    assign norm_data       = norm_data_q;
    assign norm_data_valid = norm_data_valid_q;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign out_ch          = out_ch_q;
    assign frame_done      = frame_done_q;
    assign frame_ok        = frame_ok_q;
    assign busy            = state_q != ST_IDLE;
`ifdef NORM_SCHED_TIMEOUT_EN
    assign timeout_err     = timeout_err_q;
    assign norm_flush      = norm_flush_q;
`else
    assign timeout_err     = 1'b0;
    assign norm_flush      = 1'b0;
`endif
endmodule

// File: tb/tb_norm_frame_scheduler.sv
// tb_norm_frame_scheduler: directed self-checking bench for norm_frame_scheduler (NCH=4, CNT=8, TIMEOUT=64)
module tb_norm_frame_scheduler;
    localparam int NCH = 4;
    localparam int CNT = 8;
    localparam int TMO = 64;
    localparam int FLC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = '0;
    logic [127:0]  ch_data = '0;
    logic [3:0]    ch_valid = '0;
    logic [3:0]    ch_ready, grant;
    logic          norm_start_en, norm_data_valid, norm_flush;
    logic [31:0]   norm_data, out_data;
    logic [31:0]   norm_out_data = '0;
    logic          norm_out_valid = 1'b0;
    logic          norm_end_flag = 1'b0;
    logic          out_valid, frame_done, frame_ok, timeout_err, busy;
    logic [1:0]    out_ch;

    int compared = 0, mismatched = 0;
    int cyc = 0, ndv_cnt = 0, st_cnt = 0, ov_cnt = 0, bad_out = 0, fd_cnt = 0;
    int to_cnt = 0, fl_cnt = 0, to_cyc = 0, last_ov_cyc = 0;
    logic       last_ok = 1'b0;
    logic [1:0] exp_ch = '0;

    norm_frame_scheduler #(.NCH(NCH), .CNT(CNT), .TIMEOUT(TMO), .FLUSH_CYC(FLC)) dut (
        .clk(clk), .rst(rst), .req(req), .ch_data(ch_data), .ch_valid(ch_valid),
        .ch_ready(ch_ready), .grant(grant), .norm_start_en(norm_start_en),
        .norm_data(norm_data), .norm_data_valid(norm_data_valid),
        .norm_out_data(norm_out_data), .norm_out_valid(norm_out_valid),
        .norm_end_flag(norm_end_flag), .norm_flush(norm_flush),
        .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch),
        .frame_done(frame_done), .frame_ok(frame_ok), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] nod_prev;
        nod_prev = norm_out_data;
        @(posedge clk);
        #1;
        cyc++;
        if (norm_data_valid === 1'b1) ndv_cnt++;
        if (norm_start_en === 1'b1) st_cnt++;
        if (out_valid === 1'b1) begin
            ov_cnt++;
            last_ov_cyc = cyc;
            if (out_data !== nod_prev || out_ch !== exp_ch) bad_out++;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            last_ok = frame_ok;
        end
        if (timeout_err === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (norm_flush === 1'b1) fl_cnt++;
    endtask

    task automatic frame(input int ch, input int gap, input int nout, input bit endf,
                         input bit stray, input logic [3:0] req_after, input logic exp_ok);
        int sent, guard, bad_ndv;
        bit xp;
        logic [31:0] exp_d;
        ndv_cnt = 0; st_cnt = 0; ov_cnt = 0; bad_out = 0; fd_cnt = 0; bad_ndv = 0;
        exp_ch = 2'(ch);
        guard = 0;
        while (grant === 4'b0 && guard < 20) begin
            tick();
            guard++;
        end
        chk($sformatf("grant_ch%0d", ch), 32'(grant), 32'(1 << ch));
        req = req_after;
        sent = 0;
        guard = 0;
        while (sent < CNT && guard < 200) begin
            ch_valid = (gap != 0 && guard % gap == gap - 1) ? 4'b0 : 4'(1 << ch);
            ch_data[ch*32 +: 32] = 32'hA000_0000 + 32'(ch * 256 + sent);
            exp_d = ch_data[ch*32 +: 32];
            norm_out_valid = stray && guard == 2;
            norm_out_data = 32'hDEAD_0000;
            xp = ch_ready[ch] && ch_valid[ch];
            tick();
            if (norm_data_valid !== xp || (xp && norm_data !== exp_d)) bad_ndv++;
            if (xp) sent++;
            guard++;
        end
        ch_valid = '0;
        norm_out_valid = 1'b0;
        chk("start_pulses", 32'(st_cnt), 32'd1);
        chk("ndv_pattern", 32'(bad_ndv), 32'd0);
        chk("ndv_count", 32'(ndv_cnt), 32'(CNT));
        for (int i = 0; i < nout; i++) begin
            norm_out_valid = 1'b1;
            norm_out_data = 32'h5000 + 32'(i + ch * 16);
            tick();
            norm_out_valid = 1'b0;
            tick();
        end
        if (endf) begin
            norm_end_flag = 1'b1;
            tick();
            norm_end_flag = 1'b0;
            chk("done_after_end_flag", 32'(fd_cnt), 32'd1);
        end
        guard = 0;
        while (fd_cnt == 0 && guard < 200) begin
            tick();
            guard++;
        end
        chk("frame_done_pulses", 32'(fd_cnt), 32'd1);
        chk("frame_ok", 32'(last_ok), 32'(exp_ok));
        chk("out_count", 32'(ov_cnt), 32'(nout));
        chk("out_data_tag", 32'(bad_out), 32'd0);
        tick();
        chk("grant_idle", 32'(grant), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int sent, guard;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_outs", 32'(|{ch_ready, norm_start_en, norm_data, norm_data_valid, norm_flush,
                              out_data, out_valid, out_ch, frame_done, frame_ok, timeout_err, busy}), 32'd0);
        rst = 1'b0;
        tick();

        req = 4'b1111;
        for (int i = 0; i < 5; i++) frame(i % 4, 0, CNT, 1'b1, 1'b0, (i < 4) ? 4'b1111 : 4'b0000, 1'b1);

        req = 4'b0100;
        frame(2, 0, CNT, 1'b1, 1'b0, 4'b0000, 1'b1);

        req = 4'b0010;
        frame(1, 3, CNT, 1'b1, 1'b0, 4'b0000, 1'b1);

        req = 4'b1000;
        frame(3, 0, CNT - 1, 1'b1, 1'b1, 4'b0000, 1'b0);

`ifdef NORM_SCHED_TIMEOUT_EN
        to_cnt = 0;
        fl_cnt = 0;
        req = 4'b0011;
        frame(0, 0, CNT, 1'b0, 1'b0, 4'b0010, 1'b0);
        chk("timeout_pulses", 32'(to_cnt), 32'd1);
        chk("timeout_delay", 32'(to_cyc - last_ov_cyc), 32'(TMO));
        chk("flush_cycles", 32'(fl_cnt), 32'(FLC));
        frame(1, 0, CNT, 1'b1, 1'b0, 4'b0000, 1'b1);
`else
        chk("no_timeout_err", 32'(to_cnt), 32'd0);
        chk("no_flush", 32'(fl_cnt), 32'd0);
`endif

        req = 4'b0100;
        guard = 0;
        while (grant === 4'b0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("rst_test_grant", 32'(grant), 32'b0100);
        req = 4'b0000;
        sent = 0;
        guard = 0;
        while (sent < CNT / 2 && guard < 50) begin
            ch_valid = 4'b0100;
            if (ch_ready[2]) sent++;
            tick();
            guard++;
        end
        rst = 1'b1;
        tick();
        chk("midframe_rst_grant", 32'(grant), 32'd0);
        chk("midframe_rst_outs", 32'(|{ch_ready, norm_start_en, norm_data, norm_data_valid, norm_flush,
                                       out_data, out_valid, out_ch, frame_done, frame_ok, timeout_err, busy}), 32'd0);
        rst = 1'b0;
        ch_valid = '0;
        tick();
        req = 4'b0001;
        frame(0, 0, CNT, 1'b1, 1'b0, 4'b0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
